dm_arbiter: RTL

- Shares the single-port data memory (256 x DATA_WIDTH, synchronous write, combinational read) between two requesters: the core datapath and a debug/loader port.
- The core normally wins. A debug request that waits STARVE_LIMIT cycles is forced through, and the core is stalled for that cycle.
- Sits between the core's load/store path and the data memory. Drives the memory's we/addr/d and receives its q.

---
 rtl/dm_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path and
// a debug/loader port; core wins unless debug has waited STARVE_LIMIT cycles.
module dm_arbiter #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dm_we,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic [DATA_WIDTH-1:0] dm_d,
  input  logic [DATA_WIDTH-1:0] dm_q
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  dbg_eff, dbg_grant, core_grant;

  // Grant decision; a request is masked in its own ack cycle to avoid double service
  always_comb begin
    dbg_eff    = dbg_req & ~ack_q;
    dbg_grant  = dbg_eff & (~core_req | (starve_cnt_q >= LIMIT));
    core_grant = core_req & ~dbg_grant;
  end

  always_comb begin
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_d    = '0;
    if (dbg_grant) begin
      dm_we   = dbg_we;
      dm_addr = dbg_addr;
      dm_d    = dbg_wdata;
    end else if (core_grant) begin
      dm_we   = core_we;
      dm_addr = core_addr;
      dm_d    = core_wdata;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    ack_d        = dbg_grant;
    dbg_rdata_d  = dbg_rdata_q;
    if (!dbg_req || dbg_grant) begin
      starve_cnt_d = '0;
    end else if (dbg_eff && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    if (dbg_grant && !dbg_we) begin
      dbg_rdata_d = dm_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      ack_q        <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      ack_q        <= ack_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign core_rdata = dm_q;
  assign core_stall = core_req & dbg_grant;
  assign dbg_ack    = ack_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule
